dmem_store_buffer: RTL and testbench
====================================

Name: dmem_store_buffer

Overview:
- Write-side companion to the data-memory load path.
- Accepts RV64 store requests from the MEM stage, converts each to a doubleword-aligned write with byte strobes, and queues them in a small FIFO.
- Drains the queue to data memory over a req/ack handshake.
- Flags any load that hits a doubleword with a pending store, so the pipeline can stall that load.

Parameters:
- ADDR_W, 32, byte-address width.
- DEPTH, 4, store-queue entries (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- st_valid  in  1  store request valid.
- st_ready  out  1  queue can accept (= !full, 0 while rst high).
- st_func3  in  3  000 SB, 001 SH, 010 SW, 011 SD.
- st_addr  in  ADDR_W  byte address.
- st_data  in  64  store data, right-justified.
- st_err  out  1  one-cycle pulse: previous accepted request was misaligned or had an illegal func3.
- mem_req  out  1  write request to dmem.
- mem_ack  in  1  dmem accepted the write this cycle.
- mem_addr  out  ADDR_W  doubleword address, [2:0]=0.
- mem_wdata  out  64  lane-shifted data.
- mem_wstrb  out  8  byte enables.
- ld_check  in  1  a load is in MEM this cycle.
- ld_addr  in  ADDR_W  load byte address.
- ld_hazard  out  1  load overlaps a pending store doubleword.
- sb_empty  out  1  queue empty and no request outstanding.
- sb_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, st_err=0, ld_hazard=0, sb_empty=1, sb_count=0. st_ready=0 during rst, 1 in the first cycle after.
- Acceptance: a request is accepted when st_valid && st_ready on a rising clk edge.
- Legality:
  - SH requires addr[0]=0; SW requires addr[1:0]=0; SD requires addr[2:0]=0; SB is always aligned.
  - func3[2]=1 is illegal.
  - An illegal or misaligned request is accepted (consumed) but not enqueued. st_err=1 in the following cycle only.
- Alignment:
  - size mask: SB 0x01, SH 0x03, SW 0x0F, SD 0xFF.
  - wstrb = mask << addr[2:0].
  - wdata = st_data << (8*addr[2:0]), truncated to 64 bits.
  - Stored address = {addr[ADDR_W-1:3],3'b0}.
- FIFO:
  - In-order queue with rd/wr pointers of $clog2(DEPTH)+1 bits; wrap via pointer MSB.
  - full = count==DEPTH. When full, st_ready=0 even if a pop occurs the same cycle; no full-bypass.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Drain FSM, states IDLE and REQ:
  - IDLE: if count>0, go to REQ next cycle.
  - REQ: mem_req=1; mem_addr/wdata/wstrb show the head entry and stay stable until mem_ack.
  - On mem_ack in REQ: pop head. If count after pop >0, stay in REQ with the new head next cycle (one write per cycle sustained); else go to IDLE.
  - mem_ack in IDLE is ignored.
  - First write latency: accepted at edge N, mem_req=1 after edge N+2.
- ld_hazard: combinational. ld_check && any occupied entry (including the head under request) with entry.addr[ADDR_W-1:3]==ld_addr[ADDR_W-1:3]. A store accepted in the same edge is not considered until the next cycle.
- sb_empty = (count==0) && state==IDLE.
- Reset mid-operation: all queued entries are discarded and mem_req drops after the reset edge. dmem must tolerate an abandoned request without ack.
- No byte merging or write coalescing; every legal store produces exactly one dmem write.

Decomposition:
- Shared package dmem_pkg:
  - func3 constants F3_B/F3_H/F3_W/F3_D (same encoding the load unit decodes).
  - Drain-state enum (IDLE, REQ).
  - Queue entry struct {addr, wdata, wstrb}.
- Sub-module dmem_store_align: purely combinational func3/addr/data → wstrb, wdata, aligned addr, err. Instantiated once at the enqueue side.

Test Plan:
- SB, addr 0x1005, data 0xAB, mem_ack held 1 → mem_addr 0x1000, mem_wstrb 0x20, mem_wdata 0x0000_AB00_0000_0000, mem_req high 1 cycle, sb_empty returns to 1.
- SH at 0x1001 and func3=3'b100 → st_err pulses once per request, mem_req stays 0, sb_count stays 0.
- DEPTH=4, mem_ack low, 5 back-to-back SD (0x0,0x8,0x10,0x18,0x20):
  - st_ready=0 after the 4th, sb_count=4.
  - Raise mem_ack continuously → writes issue in order 0x0..0x18 on consecutive cycles, then 0x20 is accepted and written.
- Queue holds SW at 0x2004; ld_check with ld_addr 0x2000 → ld_hazard=1; ld_addr 0x2008 → 0; after ack of that entry, 0x2000 → 0.
- 3 entries queued, mem_req high, rst pulsed one cycle → next cycle mem_req=0, sb_count=0, sb_empty=1, st_ready=1; a fresh SB afterwards writes normally.
- Simultaneous push and pop at count=2 → sb_count remains 2; pointer wrap exercised with 10 sequential stores at DEPTH=4, order preserved.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared func3 encodings, drain states and store-queue entry for the data-memory path
package dmem_pkg;
    localparam logic [2:0] F3_B = 3'b000;
    localparam logic [2:0] F3_H = 3'b001;
    localparam logic [2:0] F3_W = 3'b010;
    localparam logic [2:0] F3_D = 3'b011;
    localparam int ENTRY_AW = 64;

    typedef enum logic {IDLE, REQ} drain_t;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [63:0] wdata;
        logic [7:0] wstrb;
    } entry_t;
endpackage

// File: rtl/dmem_store_align.sv
// dmem_store_align: converts a store request into a doubleword-aligned write with byte strobes
module dmem_store_align
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       data,
    output logic [7:0]        wstrb,
    output logic [63:0]       wdata,
    output logic [ADDR_W-1:0] aaddr,
    output logic              err
);
    logic [1:0] sz;
    logic [7:0] mask;
    logic mis;

    always_comb begin
        sz = func3[1:0];
        mask = sz == F3_B[1:0] ? 8'h01 : sz == F3_H[1:0] ? 8'h03 : sz == F3_W[1:0] ? 8'h0F : 8'hFF;
        mis = sz == F3_H[1:0] ? addr[0] : sz == F3_W[1:0] ? |addr[1:0] : sz == F3_D[1:0] ? |addr[2:0] : 1'b0;
        err = func3[2] | mis;
        wstrb = mask << addr[2:0];
        wdata = data << {addr[2:0], 3'b000};
        aaddr = {addr[ADDR_W-1:3], 3'b000};
    end
endmodule

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: queues aligned RV64 stores and drains them to dmem over req/ack
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [2:0]               st_func3,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [63:0]              st_data,
    output logic                     st_err,
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [63:0]              mem_wdata,
    output logic [7:0]               mem_wstrb,
    input  logic                     ld_check,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hazard,
    output logic                     sb_empty,
    output logic [$clog2(DEPTH):0]   sb_count
);
    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = PW - 1;

    entry_t q [DEPTH];
    entry_t head;
    drain_t state;
    logic [PW-1:0] wr_ptr, rd_ptr, count, count_nxt;
    logic [7:0] a_wstrb;
    logic [63:0] a_wdata;
    logic [ADDR_W-1:0] a_addr;
    logic a_err, accept, push, pop;

    dmem_store_align #(.ADDR_W(ADDR_W)) u_align (
        .func3(st_func3),
        .addr(st_addr),
        .data(st_data),
        .wstrb(a_wstrb),
        .wdata(a_wdata),
        .aaddr(a_addr),
        .err(a_err)
    );

    assign count = wr_ptr - rd_ptr;
    assign st_ready = !rst && count != PW'(DEPTH);
    assign accept = st_valid && st_ready;
    assign push = accept && !a_err;
    assign pop = mem_req && mem_ack;
    assign count_nxt = count + PW'(push) - PW'(pop);
    assign head = q[rd_ptr[IW-1:0]];
    // head entry is held in the array until popped, so the bus stays stable without extra registers
    assign mem_addr = mem_req ? head.addr[ADDR_W-1:0] : '0;
    assign mem_wdata = mem_req ? head.wdata : '0;
    assign mem_wstrb = mem_req ? head.wstrb : '0;
    assign sb_empty = count == '0 && state == IDLE;
    assign sb_count = count;

    always_comb begin
        ld_hazard = 1'b0;
        for (int k = 0; k < DEPTH; k++)
            ld_hazard = ld_hazard | (ld_check && PW'(k) < count &&
                q[rd_ptr[IW-1:0] + IW'(k)].addr[ADDR_W-1:3] == ld_addr[ADDR_W-1:3]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            state <= IDLE;
            mem_req <= 1'b0;
            st_err <= 1'b0;
        end else begin
            st_err <= accept && a_err;
            if (push) begin
                q[wr_ptr[IW-1:0]] <= '{addr: ENTRY_AW'(a_addr), wdata: a_wdata, wstrb: a_wstrb};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (state == IDLE) begin
                if (count != '0)
                    state <= REQ;
            end else if (!mem_req) begin
                mem_req <= 1'b1;
            end else if (mem_ack && count_nxt == '0) begin
                mem_req <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: table-driven single-store vectors plus directed queue/drain sequences
module tb_dmem_store_buffer;
    logic clk = 1'b0;
    logic rst, st_valid, st_ready, st_err, mem_req, mem_ack, ld_check, ld_hazard, sb_empty;
    logic [2:0] st_func3, sb_count;
    logic [31:0] st_addr, mem_addr, ld_addr;
    logic [63:0] st_data, mem_wdata;
    logic [7:0] mem_wstrb;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] data;
        logic        err;
        logic [31:0] ea;
        logic [63:0] ed;
        logic [7:0]  es;
    } vec_t;
    vec_t v [11];

    always #5 clk = ~clk;

    dmem_store_buffer #(.ADDR_W(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready), .st_func3(st_func3),
        .st_addr(st_addr), .st_data(st_data), .st_err(st_err), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .ld_check(ld_check),
        .ld_addr(ld_addr), .ld_hazard(ld_hazard), .sb_empty(sb_empty), .sb_count(sb_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic put(input logic [2:0] f3, input logic [31:0] a, input logic [63:0] d);
        st_valid = 1'b1;
        st_func3 = f3;
        st_addr = a;
        st_data = d;
    endtask

    initial begin
        int sent, got;
        logic acc;
        v[0]  = '{3'b000, 32'h1005, 64'hAB, 1'b0, 32'h1000, 64'h0000_AB00_0000_0000, 8'h20};
        v[1]  = '{3'b001, 32'h1006, 64'h1234, 1'b0, 32'h1000, 64'h1234_0000_0000_0000, 8'hC0};
        v[2]  = '{3'b010, 32'h2004, 64'hDEAD_BEEF, 1'b0, 32'h2000, 64'hDEAD_BEEF_0000_0000, 8'hF0};
        v[3]  = '{3'b011, 32'h3008, 64'h0123_4567_89AB_CDEF, 1'b0, 32'h3008, 64'h0123_4567_89AB_CDEF, 8'hFF};
        v[4]  = '{3'b000, 32'h0, 64'hFFFF_FFFF_FFFF_FF5A, 1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_FF5A, 8'h01};
        v[5]  = '{3'b010, 32'h0013_0010, 64'h1122_3344, 1'b0, 32'h0013_0010, 64'h1122_3344, 8'h0F};
        v[6]  = '{3'b001, 32'h1001, 64'h55, 1'b1, 32'h0, 64'h0, 8'h0};
        v[7]  = '{3'b100, 32'h1000, 64'h55, 1'b1, 32'h0, 64'h0, 8'h0};
        v[8]  = '{3'b010, 32'h2002, 64'h55, 1'b1, 32'h0, 64'h0, 8'h0};
        v[9]  = '{3'b011, 32'h3004, 64'h55, 1'b1, 32'h0, 64'h0, 8'h0};
        v[10] = '{3'b111, 32'h0, 64'h55, 1'b1, 32'h0, 64'h0, 8'h0};

        rst = 1'b1;
        st_valid = 1'b0; st_func3 = '0; st_addr = '0; st_data = '0;
        mem_ack = 1'b0; ld_check = 1'b0; ld_addr = '0;
        tick;
        chk("ready_in_rst", st_ready, 0);
        tick;
        rst = 1'b0;
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_err", st_err, 0);
        chk("rst_hazard", ld_hazard, 0);
        chk("rst_empty", sb_empty, 1);
        chk("rst_count", sb_count, 0);
        chk("rst_ready", st_ready, 1);

        mem_ack = 1'b1;
        for (int i = 0; i < 11; i++) begin
            put(v[i].f3, v[i].addr, v[i].data);
            tick;
            st_valid = 1'b0;
            chk($sformatf("v%0d_err", i), st_err, v[i].err);
            if (v[i].err) begin
                tick;
                chk($sformatf("v%0d_err_pulse", i), st_err, 0);
                chk($sformatf("v%0d_noreq", i), mem_req, 0);
                chk($sformatf("v%0d_nocount", i), sb_count, 0);
            end else begin
                chk($sformatf("v%0d_count", i), sb_count, 1);
                tick;
                chk($sformatf("v%0d_req_early", i), mem_req, 0);
                tick;
                chk($sformatf("v%0d_req", i), mem_req, 1);
                chk($sformatf("v%0d_addr", i), mem_addr, v[i].ea);
                chk($sformatf("v%0d_wdata", i), mem_wdata, v[i].ed);
                chk($sformatf("v%0d_wstrb", i), mem_wstrb, v[i].es);
                tick;
                chk($sformatf("v%0d_req_drop", i), mem_req, 0);
                chk($sformatf("v%0d_empty", i), sb_empty, 1);
            end
        end

        // five back-to-back SD with dmem stalled
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(3'b011, 32'(i * 8), 64'(i + 1));
            tick;
        end
        put(3'b011, 32'h20, 64'd5);
        chk("full_ready", st_ready, 0);
        chk("full_count", sb_count, 4);
        tick;
        chk("full_hold", sb_count, 4);
        mem_ack = 1'b1;
        chk("drain0", mem_addr, 32'h0);
        tick;
        chk("drain_ready", st_ready, 1);
        chk("drain1", mem_addr, 32'h8);
        tick;
        st_valid = 1'b0;
        chk("drain_count", sb_count, 3);
        chk("drain2", mem_addr, 32'h10);
        tick;
        chk("drain3", mem_addr, 32'h18);
        tick;
        chk("drain4", mem_addr, 32'h20);
        chk("drain4_data", mem_wdata, 64'd5);
        chk("drain4_req", mem_req, 1);
        tick;
        chk("drain_done", mem_req, 0);
        chk("drain_empty", sb_empty, 1);

        // load hazard against a pending SW
        mem_ack = 1'b0;
        put(3'b010, 32'h2004, 64'h99);
        tick;
        st_valid = 1'b0;
        ld_check = 1'b1; ld_addr = 32'h2000; #1;
        chk("haz_hit", ld_hazard, 1);
        ld_addr = 32'h2008; #1;
        chk("haz_next_dw", ld_hazard, 0);
        ld_check = 1'b0; ld_addr = 32'h2003; #1;
        chk("haz_nocheck", ld_hazard, 0);
        tick;
        tick;
        chk("haz_req", mem_req, 1);
        ld_check = 1'b1; ld_addr = 32'h2007; #1;
        chk("haz_head", ld_hazard, 1);
        mem_ack = 1'b1;
        tick;
        ld_addr = 32'h2000; #1;
        chk("haz_cleared", ld_hazard, 0);
        ld_check = 1'b0;

        // reset mid-drain
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(3'b000, 32'(32'h100 + i * 8), 64'(i));
            tick;
        end
        st_valid = 1'b0;
        chk("mid_req", mem_req, 1);
        chk("mid_count", sb_count, 3);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_count", sb_count, 0);
        chk("mid_rst_empty", sb_empty, 1);
        chk("mid_rst_ready", st_ready, 1);
        mem_ack = 1'b1;
        put(3'b000, 32'h207, 64'h77);
        tick;
        st_valid = 1'b0;
        tick;
        tick;
        chk("post_rst_req", mem_req, 1);
        chk("post_rst_addr", mem_addr, 32'h200);
        chk("post_rst_wstrb", mem_wstrb, 8'h80);
        chk("post_rst_wdata", mem_wdata, 64'h7700_0000_0000_0000);
        tick;
        chk("post_rst_empty", sb_empty, 1);

        // push and pop in the same edge at count=2
        mem_ack = 1'b0;
        put(3'b011, 32'h40, 64'h40);
        tick;
        put(3'b011, 32'h48, 64'h48);
        tick;
        st_valid = 1'b0;
        tick;
        chk("pp_req", mem_req, 1);
        chk("pp_count_before", sb_count, 2);
        put(3'b011, 32'h50, 64'h50);
        mem_ack = 1'b1;
        tick;
        st_valid = 1'b0;
        chk("pp_count", sb_count, 2);
        chk("pp_head1", mem_addr, 32'h48);
        tick;
        chk("pp_head2", mem_addr, 32'h50);
        chk("pp_head2_data", mem_wdata, 64'h50);
        tick;
        chk("pp_empty", sb_empty, 1);

        // ten streamed stores through the 4-deep queue, order preserved across pointer wrap
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
            if (sent < 10) put(3'b011, 32'(32'h400 + sent * 8), 64'(sent));
            else st_valid = 1'b0;
            mem_ack = (cyc % 3) != 1;
            #1;
            if (mem_req && mem_ack) begin
                chk($sformatf("wrap_addr%0d", got), mem_addr, 32'(32'h400 + got * 8));
                chk($sformatf("wrap_data%0d", got), mem_wdata, 64'(got));
                got++;
            end
            acc = st_valid && st_ready;
            tick;
            if (acc) sent++;
        end
        st_valid = 1'b0;
        chk("wrap_all_written", 64'(got), 64'd10);
        tick;
        chk("wrap_empty", sb_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
